sha2_msg_sched_stream: RTL and testbench

//  Parametrised SHA-2 message-schedule expander with valid/ready streaming on both sides.

---
 rtl/sha2_msg_sched_stream.sv | 217 +++++++++++++++++++++
 tb/tb_sha2_msg_sched_stream.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_sched_stream.sv
// sha2_msg_sched_stream
//   SHA-2 message-schedule expander with valid/ready handshakes on both sides.
//   Takes the 16 message words of a block, passes each one straight through as
//   W[0..15], then generates W[16..NUM_ROUNDS-1] from a 16-word sliding window.
//   WORD_W selects the sigma functions: 32 for SHA-256, 64 for SHA-512.
//
//   Build option: define SHA2_SCHED_PIPE_EN to split the four-input schedule
//   add over two cycles (two partial sums, then their total). Expanded words
//   then come out every second cycle. The word values are the same as in the
//   single-cycle build. Without the macro, each expanded word is one
//   four-input add.

module sha2_msg_sched_stream #(
    parameter int WORD_W     = 32,
    parameter int NUM_ROUNDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              blk_start,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [WORD_W-1:0] m_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_word,
    output logic [6:0]        w_round,
    output logic              w_last,
    output logic              busy
);

    // Only the two SHA-2 word sizes have defined sigma functions.
    generate
        if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
            $error("sha2_msg_sched_stream: WORD_W must be 32 or 64");
        end
        if (NUM_ROUNDS < 17 || NUM_ROUNDS > 127) begin : g_bad_rounds
            $error("sha2_msg_sched_stream: NUM_ROUNDS must be in 17..127");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_EXPAND,
        S_DRAIN
    } state_t;

    localparam logic [6:0] LAST_T      = 7'(NUM_ROUNDS - 1);
    localparam logic [6:0] LOAD_LAST_T = 7'd15;

    // Rotate and shift amounts for the two sigma functions, selected by word size.
    localparam int S0_R1 = (WORD_W == 64) ? 1  : 7;
    localparam int S0_R2 = (WORD_W == 64) ? 8  : 18;
    localparam int S0_SH = (WORD_W == 64) ? 7  : 3;
    localparam int S1_R1 = (WORD_W == 64) ? 19 : 17;
    localparam int S1_R2 = (WORD_W == 64) ? 61 : 19;
    localparam int S1_SH = (WORD_W == 64) ? 6  : 10;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
        return rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);
    endfunction

    function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
        return rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);
    endfunction

    state_t            state;
    state_t            state_next;
    logic [6:0]        t;
    logic [WORD_W-1:0] win [16];
    logic              slot_free;
    logic              load_word;
    logic              expand_word;
    logic [WORD_W-1:0] w_next;
    logic [WORD_W-1:0] new_word;

    // The output register can take a new word when it is empty or being drained this cycle.
    assign slot_free = !w_valid || w_ready;

`ifdef SHA2_SCHED_PIPE_EN
    logic              phase_b;
    logic [WORD_W-1:0] p0;
    logic [WORD_W-1:0] p1;

    assign w_next = p0 + p1;
`else
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
`endif

    assign new_word = load_word ? m_word : w_next;

    // Next-state and handshake decode. blk_start wins over everything, including a waiting m_valid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next  = state;
        m_ready     = 1'b0;
        load_word   = 1'b0;
        expand_word = 1'b0;
        if (blk_start) begin
            state_next = S_LOAD;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_next = S_IDLE;
                end
                S_LOAD: begin
                    m_ready = slot_free;
                    if (m_valid && slot_free) begin
                        load_word = 1'b1;
                        if (t == LOAD_LAST_T) begin
                            state_next = S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
`ifdef SHA2_SCHED_PIPE_EN
                    if (phase_b && slot_free) begin
`else
                    if (slot_free) begin
`endif
                        expand_word = 1'b1;
                        if (t == LAST_T) begin
                            state_next = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_ready) begin
                        state_next = S_IDLE;
                    end
                end
            endcase
        end
    end

    // State register. busy follows the state, so it is high from the start pulse until the last word is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != S_IDLE);
        end
    end

    // Sliding window of the last 16 schedule words. win[0] is the oldest word and win[15] the newest.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the window is a flop array rather than a RAM. It takes the async reset so a block cut short by reset leaves nothing behind.
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (blk_start) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load_word || expand_word) begin
            for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
            end
            win[15] <= new_word;
        end
    end

    // Output slot and round counter. Under back-pressure nothing here changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_valid <= 1'b0;
            w_word  <= '0;
            w_round <= '0;
            w_last  <= 1'b0;
            t       <= '0;
        end else if (blk_start) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
            t       <= '0;
        end else if (load_word || expand_word) begin
            w_valid <= 1'b1;
            w_word  <= new_word;
            w_round <= t;
            w_last  <= expand_word && (t == LAST_T);
            t       <= t + 7'd1;
        end else if (w_ready) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end
    end

`ifdef SHA2_SCHED_PIPE_EN
    // Two-phase expansion. Phase A registers the partial sums from the current window.
    // Phase B loads their total into the output slot once the slot is free.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_b <= 1'b0;
            p0      <= '0;
            p1      <= '0;
        end else if (blk_start) begin
            phase_b <= 1'b0;
        end else if (state == S_EXPAND) begin
            if (!phase_b) begin
                p0      <= sigma0(win[1]) + win[0];
                p1      <= sigma1(win[14]) + win[9];
                phase_b <= 1'b1;
            end else if (expand_word) begin
                phase_b <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha2_msg_sched_stream.sv
// Directed bench for sha2_msg_sched_stream. One 32-bit/64-round instance and one
// 64-bit/80-round instance share the control inputs; sel64 picks which one is observed.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_sha2_msg_sched_stream;

`ifdef SHA2_SCHED_PIPE_EN
    localparam int EXP_SPACING = 2;
`else
    localparam int EXP_SPACING = 1;
`endif

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        blk_start = 1'b0;
    logic        m_valid   = 1'b0;
    logic        w_ready   = 1'b0;
    logic [63:0] m_word_in = '0;

    logic        m_ready32, w_valid32, w_last32, busy32;
    logic [31:0] w_word32;
    logic [6:0]  w_round32;
    logic        m_ready64, w_valid64, w_last64, busy64;
    logic [63:0] w_word64;
    logic [6:0]  w_round64;

    bit          sel64 = 1'b0;
    logic        cur_m_ready, cur_valid, cur_last, cur_busy;
    logic [63:0] cur_word;
    logic [6:0]  cur_round;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [63:0] msg      [16];
    logic [63:0] exp_w    [80];
    logic [63:0] got_word [80];
    int          got_round[80];
    bit          got_last [80];
    int          got_cyc  [80];
    logic [63:0] stall_word [5];
    int          stall_round[5];

    always #5 clk = ~clk;

    sha2_msg_sched_stream #(.WORD_W(32), .NUM_ROUNDS(64)) dut32 (
        .clk       (clk),
        .reset_n   (reset_n),
        .blk_start (blk_start),
        .m_valid   (m_valid),
        .m_ready   (m_ready32),
        .m_word    (m_word_in[31:0]),
        .w_valid   (w_valid32),
        .w_ready   (w_ready),
        .w_word    (w_word32),
        .w_round   (w_round32),
        .w_last    (w_last32),
        .busy      (busy32)
    );

    sha2_msg_sched_stream #(.WORD_W(64), .NUM_ROUNDS(80)) dut64 (
        .clk       (clk),
        .reset_n   (reset_n),
        .blk_start (blk_start),
        .m_valid   (m_valid),
        .m_ready   (m_ready64),
        .m_word    (m_word_in),
        .w_valid   (w_valid64),
        .w_ready   (w_ready),
        .w_word    (w_word64),
        .w_round   (w_round64),
        .w_last    (w_last64),
        .busy      (busy64)
    );

    always_comb begin
        if (sel64) begin
            cur_m_ready = m_ready64;
            cur_valid   = w_valid64;
            cur_last    = w_last64;
            cur_busy    = busy64;
            cur_word    = w_word64;
            cur_round   = w_round64;
        end else begin
            cur_m_ready = m_ready32;
            cur_valid   = w_valid32;
            cur_last    = w_last32;
            cur_busy    = busy32;
            cur_word    = {32'h0, w_word32};
            cur_round   = w_round32;
        end
    end

    // ---------------- reference model (index form of the recurrence) ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    task automatic build_model(input bit is64, input int rounds);
        logic [63:0] a64, b64;
        logic [31:0] a32, b32, s32;
        for (int i = 0; i < rounds; i++) begin
            if (i < 16) begin
                exp_w[i] = msg[i];
            end else if (is64) begin
                a64 = exp_w[i-15];
                b64 = exp_w[i-2];
                exp_w[i] = (ror64(b64, 19) ^ ror64(b64, 61) ^ (b64 >> 6)) + exp_w[i-7]
                         + (ror64(a64, 1) ^ ror64(a64, 8) ^ (a64 >> 7)) + exp_w[i-16];
            end else begin
                a32 = exp_w[i-15][31:0];
                b32 = exp_w[i-2][31:0];
                s32 = (ror32(b32, 17) ^ ror32(b32, 19) ^ (b32 >> 10)) + exp_w[i-7][31:0]
                    + (ror32(a32, 7) ^ ror32(a32, 18) ^ (a32 >> 3)) + exp_w[i-16][31:0];
                exp_w[i] = {32'h0, s32};
            end
        end
    endtask

    task automatic set_abc(input bit is64);
        for (int i = 0; i < 16; i++) msg[i] = 64'h0;
        msg[0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
        msg[15] = 64'h18;
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    endtask

    // Counts word/round and last-flag disagreements with the model over a captured block.
    task automatic seq_errors(input int rounds, output int bad, output int first, output int bad_last);
        bad = 0;
        first = 0;
        bad_last = 0;
        for (int i = 0; i < rounds; i++) begin
            if (got_word[i] !== exp_w[i] || got_round[i] != i) begin
                if (bad == 0) first = i;
                bad++;
            end
            if (got_last[i] != (i == rounds - 1)) bad_last++;
        end
    endtask

    // Feeds msg[] and captures accepted output words.
    // mode 0: w_ready always 1; mode 1: 5-cycle stall at round 20; mode 2: random w_ready.
    task automatic run_block(input bit is64, input int rounds, input int mode, input bit do_start,
                             input int max_cycles, output int n_got, output bit timed_out);
        int mi;
        int stall_left;
        bit stalled;
        sel64 = is64;
        n_got = 0;
        mi = 0;
        stall_left = 0;
        stalled = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 80; i++) begin
            got_word[i] = 'x;
            got_round[i] = -1;
            got_last[i] = 1'b0;
            got_cyc[i] = -1;
        end
        if (do_start) begin
            blk_start = 1'b1;
            m_valid = 1'b0;
            w_ready = 1'b1;
            @(negedge clk);
            blk_start = 1'b0;
        end
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            m_valid = (mi < 16);
            if (mi < 16) m_word_in = msg[mi];
            else m_word_in = 64'h0;
            if (mode == 1 && !stalled && cur_valid && cur_round == 7'd20) begin
                stall_left = 5;
                stalled = 1'b1;
            end
            if (stall_left > 0) begin
                w_ready = 1'b0;
                stall_word[5-stall_left] = cur_word;
                stall_round[5-stall_left] = int'(cur_round);
                stall_left--;
            end else if (mode == 2) begin
                w_ready = 1'($urandom_range(0, 1));
            end else begin
                w_ready = 1'b1;
            end
            #1;
            if (m_valid && cur_m_ready) mi++;
            if (cur_valid && w_ready && n_got < 80) begin
                got_word[n_got] = cur_word;
                got_round[n_got] = int'(cur_round);
                got_last[n_got] = cur_last;
                got_cyc[n_got] = cyc;
                n_got++;
            end
            @(negedge clk);
            if (n_got == rounds) begin
                timed_out = 1'b0;
                break;
            end
        end
        m_valid = 1'b0;
        w_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({m_ready32, w_valid32, w_word32, w_round32, w_last32, busy32} !== '0) begin
            n_fail++;
            $display("FAIL reset32: outputs %b %b %h %0d %b %b, required all 0",
                     m_ready32, w_valid32, w_word32, w_round32, w_last32, busy32);
        end
        n_checks++;
        if ({m_ready64, w_valid64, w_word64, w_round64, w_last64, busy64} !== '0) begin
            n_fail++;
            $display("FAIL reset64: outputs %b %b %h %0d %b %b, required all 0",
                     m_ready64, w_valid64, w_word64, w_round64, w_last64, busy64);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_abc256();
        int n, bad, first, bad_last, bad_gap;
        bit to;
        set_abc(1'b0);
        build_model(1'b0, 64);
        run_block(1'b0, 64, 0, 1'b1, 400, n, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL abc256_timeout: got %0d words, required 64", n); end
        n_checks++;
        if (got_word[16] !== 64'h61626380) begin n_fail++; $display("FAIL abc256_w16: got %h required 61626380", got_word[16]); end
        n_checks++;
        if (got_word[17] !== 64'h000F0000) begin n_fail++; $display("FAIL abc256_w17: got %h required 000f0000", got_word[17]); end
        n_checks++;
        if (got_word[18] !== 64'h7DA86405) begin n_fail++; $display("FAIL abc256_w18: got %h required 7da86405", got_word[18]); end
        n_checks++;
        if (got_word[19] !== 64'h600003C6) begin n_fail++; $display("FAIL abc256_w19: got %h required 600003c6", got_word[19]); end
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abc256_seq: %0d bad, first t=%0d got %h/%0d required %h/%0d",
                     bad, first, got_word[first], got_round[first], exp_w[first], first);
        end
        n_checks++;
        if (bad_last != 0) begin n_fail++; $display("FAIL abc256_last: %0d words with wrong w_last, required only t=63", bad_last); end
        n_checks++;
        if (got_cyc[0] != 1) begin n_fail++; $display("FAIL abc256_latency: M0 seen at cycle %0d, required 1", got_cyc[0]); end
        bad_gap = 0;
        for (int i = 1; i < 64; i++) begin
            if (got_cyc[i] - got_cyc[i-1] != ((i < 16) ? 1 : EXP_SPACING)) bad_gap++;
        end
        n_checks++;
        if (bad_gap != 0) begin n_fail++; $display("FAIL abc256_spacing: %0d gaps wrong, required load 1 expand %0d", bad_gap, EXP_SPACING); end
        n_checks++;
        if (cur_busy !== 1'b0 || cur_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abc256_idle: busy %b w_valid %b, required 0 0", cur_busy, cur_valid);
        end
    endtask

    task automatic test_abc512();
        int n, bad, first, bad_last;
        bit to;
        set_abc(1'b1);
        build_model(1'b1, 80);
        run_block(1'b1, 80, 0, 1'b1, 600, n, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL abc512_timeout: got %0d words, required 80", n); end
        n_checks++;
        if (got_word[16] !== 64'h6162638000000000) begin n_fail++; $display("FAIL abc512_w16: got %h required 6162638000000000", got_word[16]); end
        n_checks++;
        if (got_word[17] !== 64'h00030000000000C0) begin n_fail++; $display("FAIL abc512_w17: got %h required 00030000000000c0", got_word[17]); end
        seq_errors(80, bad, first, bad_last);
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abc512_seq: %0d bad, first t=%0d got %h required %h", bad, first, got_word[first], exp_w[first]);
        end
        n_checks++;
        if (bad_last != 0 || got_round[79] != 79) begin
            n_fail++;
            $display("FAIL abc512_last: %0d wrong w_last, final round %0d, required last only at 79", bad_last, got_round[79]);
        end
    endtask

    task automatic test_backpressure();
        int n, bad, first, bad_last, bad_stall;
        bit to;
        set_abc(1'b0);
        build_model(1'b0, 64);
        run_block(1'b0, 64, 1, 1'b1, 400, n, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_timeout: got %0d words, required 64", n); end
        bad_stall = 0;
        for (int i = 0; i < 5; i++) begin
            if (stall_word[i] !== exp_w[20] || stall_round[i] != 20) bad_stall++;
        end
        n_checks++;
        if (bad_stall != 0) begin
            n_fail++;
            $display("FAIL bp_frozen: %0d stall cycles moved, last %h/%0d required %h/20",
                     bad_stall, stall_word[4], stall_round[4], exp_w[20]);
        end
        n_checks++;
        if (got_word[21] !== exp_w[21] || got_round[21] != 21) begin
            n_fail++;
            $display("FAIL bp_w21: got %h/%0d required %h/21", got_word[21], got_round[21], exp_w[21]);
        end
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (bad != 0 || bad_last != 0) begin
            n_fail++;
            $display("FAIL bp_seq: %0d bad words (first t=%0d got %h required %h), %0d bad w_last",
                     bad, first, got_word[first], exp_w[first], bad_last);
        end
        // Random w_ready must not change the sequence.
        run_block(1'b0, 64, 2, 1'b1, 1500, n, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL rnd_timeout: got %0d words, required 64", n); end
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (bad != 0 || bad_last != 0) begin
            n_fail++;
            $display("FAIL rnd_seq: %0d bad words (first t=%0d got %h required %h), %0d bad w_last",
                     bad, first, got_word[first], exp_w[first], bad_last);
        end
    endtask

    task automatic test_abort();
        int n, bad, first, bad_last, mi;
        bit to, found;
        sel64 = 1'b0;
        set_abc(1'b0);
        blk_start = 1'b1;
        m_valid = 1'b0;
        w_ready = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        mi = 0;
        found = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cur_valid && cur_round == 7'd30) begin
                found = 1'b1;
                break;
            end
            m_valid = (mi < 16);
            if (mi < 16) m_word_in = msg[mi];
            #1;
            if (m_valid && cur_m_ready) mi++;
            @(negedge clk);
        end
        m_valid = 1'b0;
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL abort_reach30: round 30 not seen, required within 300 cycles"); end
        blk_start = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        n_checks++;
        if (cur_valid !== 1'b0 || cur_last !== 1'b0 || cur_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_drop: w_valid %b w_last %b busy %b, required 0 0 1", cur_valid, cur_last, cur_busy);
        end
        #1;
        n_checks++;
        if (cur_m_ready !== 1'b1) begin n_fail++; $display("FAIL abort_mready: m_ready %b, required 1", cur_m_ready); end
        @(negedge clk);
        set_zero();
        build_model(1'b0, 64);
        run_block(1'b0, 64, 0, 1'b0, 400, n, to);
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (to || bad != 0 || bad_last != 0) begin
            n_fail++;
            $display("FAIL abort_zero_block: timeout %b, %0d bad (first t=%0d got %h/%0d required 0/%0d), %0d bad w_last",
                     to, bad, first, got_word[first], got_round[first], first, bad_last);
        end
    endtask

    task automatic test_start_collision();
        int n, bad, first, bad_last;
        bit to;
        sel64 = 1'b0;
        set_abc(1'b0);
        blk_start = 1'b1;
        w_ready = 1'b1;
        @(negedge clk);
        blk_start = 1'b0;
        // Load a few junk words so a missed window clear would be visible later.
        for (int i = 0; i < 3; i++) begin
            m_valid = 1'b1;
            m_word_in = 64'hDEADBEEF + 64'(i);
            @(negedge clk);
        end
        blk_start = 1'b1;
        m_valid = 1'b1;
        m_word_in = msg[0];
        #1;
        n_checks++;
        if (cur_m_ready !== 1'b0) begin n_fail++; $display("FAIL collide_mready: m_ready %b with blk_start, required 0", cur_m_ready); end
        @(negedge clk);
        blk_start = 1'b0;
        m_valid = 1'b0;
        build_model(1'b0, 64);
        run_block(1'b0, 64, 0, 1'b0, 400, n, to);
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (to || bad != 0 || bad_last != 0) begin
            n_fail++;
            $display("FAIL collide_block: timeout %b, %0d bad (first t=%0d got %h required %h)",
                     to, bad, first, got_word[first], exp_w[first]);
        end
    endtask

    task automatic test_reset_mid();
        int n, bad, first, bad_last;
        bit to;
        set_abc(1'b0);
        build_model(1'b0, 64);
        run_block(1'b0, 64, 0, 1'b1, 30, n, to);
        n_checks++;
        if (cur_busy !== 1'b1 || to !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_inflight: busy %b timed_out %b words %0d, required 1 1 <64", cur_busy, to, n);
        end
        w_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cur_m_ready, cur_valid, cur_word, cur_round, cur_last, cur_busy} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async: outputs %b %b %h %0d %b %b, required all 0",
                     cur_m_ready, cur_valid, cur_word, cur_round, cur_last, cur_busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_block(1'b0, 64, 0, 1'b1, 400, n, to);
        seq_errors(64, bad, first, bad_last);
        n_checks++;
        if (to || bad != 0 || bad_last != 0) begin
            n_fail++;
            $display("FAIL rstmid_fresh: timeout %b, %0d bad (first t=%0d got %h required %h)",
                     to, bad, first, got_word[first], exp_w[first]);
        end
    endtask

    initial begin
        test_reset();
        test_abc256();
        test_abc512();
        test_backpressure();
        test_abort();
        test_start_collision();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
